load_store_unit: RTL and testbench

Sub-word access engine between the memory stage of the RISC-V pipeline and the word-addressed `data_memory`. It accepts one load/store request at a time from the core, converts byte addresses to word indices, performs read-modify-write for SB/SH, extracts and sign/zero-extends load data, and returns a single-cycle response. Misaligned or illegal requests are flagged without touching memory.

---
 rtl/load_store_unit.sv | 85 ++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: sub-word load/store engine between the pipeline memory stage and word-addressed data_memory
// Ports: clk/reset (async active-low); req_* = one load/store request per handshake (ready only in IDLE);
// resp_* = one-cycle response pulse with held rdata/err; mem_A/mem_WD/mem_WE/mem_RD = word port to data_memory.
module load_store_unit #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, state_n;
  logic [31:0] addr_q, wdata_q, rd_buf, addr_a, lane, merged;
  logic [2:0]  f3_q;
  logic        we_q, accept, illegal, misaligned, err;
  logic [7:0]  byte_l;
  logic [15:0] half_l;
  assign accept     = req_valid && state == IDLE;
  assign illegal    = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2]);
  assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3 == 3'b010 && |req_addr[1:0]);
  assign err        = illegal || (MISALIGN_TRAP && misaligned);
  // Without trapping, misaligned accesses are silently forced to natural alignment.
  assign addr_a = MISALIGN_TRAP ? req_addr :
                  req_funct3[1:0] == 2'b01 ? {req_addr[31:1], 1'b0} :
                  req_funct3[1:0] == 2'b10 ? {req_addr[31:2], 2'b00} : req_addr;
  assign byte_l = mem_RD[8*addr_q[1:0] +: 8];
  assign half_l = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
  assign lane   = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & byte_l[7]}}, byte_l} :
                  f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & half_l[15]}}, half_l} : mem_RD;
  always_comb begin
    merged = rd_buf;
    if (f3_q[1:0] == 2'b00) merged[8*addr_q[1:0] +: 8] = wdata_q[7:0];
    else if (f3_q[1:0] == 2'b01) merged[16*addr_q[1] +: 16] = wdata_q[15:0];
    else merged = wdata_q;
  end
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE  ? (accept ? (err ? RESP : (req_we && req_funct3[1:0] == 2'b10) ? WRITE : READ) : IDLE) :
              state == READ  ? (we_q ? WRITE : RESP) :
              state == WRITE ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rd_buf     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q     <= addr_a;
        f3_q       <= req_funct3;
        we_q       <= req_we;
        wdata_q    <= req_wdata;
        resp_rdata <= '0;
        resp_err   <= err;
      end
      if (state == READ) begin
        rd_buf <= mem_RD;
        if (!we_q) resp_rdata <= lane;
      end
    end
  // Memory controls come from the state register alone, so reset kills a write at once.
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign mem_WE     = state == WRITE;
  assign mem_WD     = state == WRITE ? merged : '0;
  assign mem_A      = {2'b00, addr_q[31:2]};
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit (trapping and non-trapping instances)
module tb_load_store_unit;
  logic        clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_we = 1'b0, sel = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        val1, val0, r1, r0, v1, v0, e1, e0, we1, we0;
  logic [31:0] rd1, rd0, a1, a0, wd1, wd0, mrd1, mrd0;
  logic        ready, rvalid, rerr, mwe;
  logic [31:0] rdata, ma, mwd;
  logic [31:0] mem1 [256];
  logic [31:0] mem0 [256];
  logic        bd_we = 1'b0, bd_sel = 1'b0;
  logic [7:0]  bd_a = '0;
  logic [31:0] bd_d = '0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign val1 = req_valid && !sel;
  assign val0 = req_valid && sel;
  assign ready  = sel ? r0 : r1;
  assign rvalid = sel ? v0 : v1;
  assign rerr   = sel ? e0 : e1;
  assign mwe    = sel ? we0 : we1;
  assign rdata  = sel ? rd0 : rd1;
  assign ma     = sel ? a0 : a1;
  assign mwd    = sel ? wd0 : wd1;
  assign mrd1 = mem1[a1[7:0]];
  assign mrd0 = mem0[a0[7:0]];
  always @(posedge clk) begin
    if (we1) mem1[a1[7:0]] <= wd1;
    else if (bd_we && !bd_sel) mem1[bd_a] <= bd_d;
    if (we0) mem0[a0[7:0]] <= wd0;
    else if (bd_we && bd_sel) mem0[bd_a] <= bd_d;
  end
  load_store_unit #(.MISALIGN_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(val1), .req_ready(r1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(v1), .resp_rdata(rd1), .resp_err(e1),
    .mem_A(a1), .mem_WD(wd1), .mem_WE(we1), .mem_RD(mrd1)
  );
  load_store_unit #(.MISALIGN_TRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(val0), .req_ready(r0), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(v0), .resp_rdata(rd0), .resp_err(e0),
    .mem_A(a0), .mem_WD(wd0), .mem_WE(we0), .mem_RD(mrd0)
  );
  task automatic preload(input logic s, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_sel = s; bd_a = a; bd_d = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask
  // Issues one request and reports cycles from accept edge to the response sample.
  task automatic issue(input logic s, input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int wes, output logic [31:0] rd, output logic er, output logic [31:0] adr);
    @(negedge clk);
    sel = s; req_valid = 1'b1; req_we = w; req_funct3 = f; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    wes = 0;
    while (!rvalid && lat < 10) begin
      wes += int'(mwe);
      @(negedge clk);
      lat++;
    end
    rd = rdata; er = rerr; adr = ma;
    @(negedge clk);
  endtask
  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", ready); end
    tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b exp 0", rvalid); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    tests++; if (rerr !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", rerr); end
    tests++; if (mwe !== 1'b0 || mwd !== 32'h0) begin fails++; $display("FAIL reset_mem_wr got we=%b wd=%h exp 0", mwe, mwd); end
    tests++; if (ma !== 32'h0) begin fails++; $display("FAIL reset_mem_A got %h exp 0", ma); end
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_reset_mid_sb;
    preload(1'b0, 8'h50, 32'hAABBCCDD);
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h140; req_wdata = 32'h11;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    tests++; if (mwe !== 1'b1) begin fails++; $display("FAIL midsb_write_state got we=%b exp 1", mwe); end
    reset = 1'b0;
    #1;
    tests++; if (mwe !== 1'b0) begin fails++; $display("FAIL midsb_we_async got %b exp 0", mwe); end
    tests++; if (mwd !== 32'h0 || ma !== 32'h0) begin fails++; $display("FAIL midsb_mem_port got wd=%h a=%h exp 0", mwd, ma); end
    tests++; if (rvalid !== 1'b0 || rdata !== 32'h0 || rerr !== 1'b0) begin fails++; $display("FAIL midsb_resp got v=%b d=%h e=%b exp 0", rvalid, rdata, rerr); end
    @(posedge clk);
    @(negedge clk);
    tests++; if (mem1[8'h50] !== 32'hAABBCCDD) begin fails++; $display("FAIL midsb_mem_unchanged got %h exp aabbccdd", mem1[8'h50]); end
    reset = 1'b1;
    @(negedge clk);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL midsb_ready_after got %b exp 1", ready); end
  endtask
  task automatic test_sw_lw;
    int lat, wes;
    logic [31:0] rd, adr;
    logic er;
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, wes, rd, er, adr);
    tests++; if (lat !== 2) begin fails++; $display("FAIL sw_latency got %0d exp 2", lat); end
    tests++; if (wes !== 1) begin fails++; $display("FAIL sw_we_cycles got %0d exp 1", wes); end
    tests++; if (adr !== 32'h40) begin fails++; $display("FAIL sw_mem_A got %h exp 00000040", adr); end
    tests++; if (rd !== 32'h0 || er !== 1'b0) begin fails++; $display("FAIL sw_resp got d=%h e=%b exp 0/0", rd, er); end
    tests++; if (mem1[8'h40] !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_mem got %h exp deadbeef", mem1[8'h40]); end
    issue(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, lat, wes, rd, er, adr);
    tests++; if (lat !== 2) begin fails++; $display("FAIL lw_latency got %0d exp 2", lat); end
    tests++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin fails++; $display("FAIL lw_data got d=%h e=%b exp deadbeef/0", rd, er); end
    tests++; if (wes !== 0) begin fails++; $display("FAIL lw_no_write got %0d exp 0", wes); end
  endtask
  task automatic test_sub_store;
    int lat, wes;
    logic [31:0] rd, adr;
    logic er;
    issue(1'b0, 1'b1, 3'b000, 32'h102, 32'hAAAAAA55, lat, wes, rd, er, adr);
    tests++; if (lat !== 3) begin fails++; $display("FAIL sb_latency got %0d exp 3", lat); end
    tests++; if (wes !== 1) begin fails++; $display("FAIL sb_we_cycles got %0d exp 1", wes); end
    issue(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, lat, wes, rd, er, adr);
    tests++; if (rd !== 32'hDE55BEEF) begin fails++; $display("FAIL sb_merge got %h exp de55beef", rd); end
    issue(1'b0, 1'b1, 3'b001, 32'h102, 32'hFFFF1234, lat, wes, rd, er, adr);
    tests++; if (lat !== 3 || er !== 1'b0) begin fails++; $display("FAIL sh_latency got %0d e=%b exp 3/0", lat, er); end
    issue(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, lat, wes, rd, er, adr);
    tests++; if (rd !== 32'h1234BEEF) begin fails++; $display("FAIL sh_merge got %h exp 1234beef", rd); end
  endtask
  task automatic test_loads;
    int lat, wes;
    logic [31:0] rd, adr;
    logic er;
    preload(1'b0, 8'h80, 32'h8081F2F3);
    issue(1'b0, 1'b0, 3'b000, 32'h203, 32'h0, lat, wes, rd, er, adr);
    tests++; if (rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb got %h exp ffffff80", rd); end
    issue(1'b0, 1'b0, 3'b100, 32'h203, 32'h0, lat, wes, rd, er, adr);
    tests++; if (rd !== 32'h00000080) begin fails++; $display("FAIL lbu got %h exp 00000080", rd); end
    issue(1'b0, 1'b0, 3'b001, 32'h200, 32'h0, lat, wes, rd, er, adr);
    tests++; if (rd !== 32'hFFFFF2F3) begin fails++; $display("FAIL lh got %h exp fffff2f3", rd); end
    issue(1'b0, 1'b0, 3'b101, 32'h202, 32'h0, lat, wes, rd, er, adr);
    tests++; if (rd !== 32'h00008081 || lat !== 2) begin fails++; $display("FAIL lhu got %h lat %0d exp 00008081/2", rd, lat); end
  endtask
  task automatic test_errors;
    int lat, wes;
    logic [31:0] rd, adr;
    logic er;
    issue(1'b0, 1'b0, 3'b010, 32'h101, 32'h0, lat, wes, rd, er, adr);
    tests++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || wes !== 0) begin fails++; $display("FAIL lw_misaligned got lat=%0d e=%b d=%h we=%0d exp 1/1/0/0", lat, er, rd, wes); end
    issue(1'b0, 1'b1, 3'b001, 32'h203, 32'h9999, lat, wes, rd, er, adr);
    tests++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || wes !== 0) begin fails++; $display("FAIL sh_misaligned got lat=%0d e=%b d=%h we=%0d exp 1/1/0/0", lat, er, rd, wes); end
    issue(1'b0, 1'b0, 3'b011, 32'h100, 32'h0, lat, wes, rd, er, adr);
    tests++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL f3_011 got lat=%0d e=%b d=%h exp 1/1/0", lat, er, rd); end
    issue(1'b0, 1'b1, 3'b100, 32'h100, 32'h77, lat, wes, rd, er, adr);
    tests++; if (lat !== 1 || er !== 1'b1 || wes !== 0) begin fails++; $display("FAIL store_bu got lat=%0d e=%b we=%0d exp 1/1/0", lat, er, wes); end
    issue(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, lat, wes, rd, er, adr);
    tests++; if (er !== 1'b0 || rd !== 32'h1234BEEF) begin fails++; $display("FAIL err_clear got e=%b d=%h exp 0/1234beef", er, rd); end
  endtask
  task automatic test_no_trap;
    int lat, wes;
    logic [31:0] rd, adr;
    logic er;
    preload(1'b1, 8'h40, 32'h11223344);
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, lat, wes, rd, er, adr);
    tests++; if (lat !== 2 || er !== 1'b0 || rd !== 32'h11223344) begin fails++; $display("FAIL notrap_lw got lat=%0d e=%b d=%h exp 2/0/11223344", lat, er, rd); end
    issue(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, lat, wes, rd, er, adr);
    tests++; if (er !== 1'b0 || rd !== 32'h00001122) begin fails++; $display("FAIL notrap_lh got e=%b d=%h exp 0/00001122", er, rd); end
    sel = 1'b0;
  endtask
  task automatic test_back_to_back;
    logic        rw [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  rf [3] = '{3'b010, 3'b001, 3'b100};
    logic [31:0] ra [3] = '{32'h100, 32'h100, 32'h101};
    logic [31:0] rdt [3] = '{32'h0, 32'h0000CAFE, 32'h0};
    logic [31:0] got [4];
    logic        ge [4];
    int n = 0, idx = 0, low = 0;
    sel = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rvalid) begin
        if (n < 4) begin got[n] = rdata; ge[n] = rerr; end
        n++;
      end
      if (idx < 3) begin
        req_valid = 1'b1; req_we = rw[idx]; req_funct3 = rf[idx]; req_addr = ra[idx]; req_wdata = rdt[idx];
        if (ready) idx++;
        else low++;
      end else req_valid = 1'b0;
    end
    tests++; if (n !== 3) begin fails++; $display("FAIL b2b_count got %0d exp 3", n); end
    if (n >= 3) begin
      tests++; if (got[0] !== 32'h1234BEEF || ge[0] !== 1'b0) begin fails++; $display("FAIL b2b_lw got %h/%b exp 1234beef/0", got[0], ge[0]); end
      tests++; if (got[1] !== 32'h0 || ge[1] !== 1'b0) begin fails++; $display("FAIL b2b_sh got %h/%b exp 0/0", got[1], ge[1]); end
      tests++; if (got[2] !== 32'h000000CA || ge[2] !== 1'b0) begin fails++; $display("FAIL b2b_lbu got %h/%b exp 000000ca/0", got[2], ge[2]); end
    end
    tests++; if (low < 1) begin fails++; $display("FAIL b2b_ready_low got %0d exp >0", low); end
    tests++; if (mem1[8'h40] !== 32'h1234CAFE) begin fails++; $display("FAIL b2b_mem got %h exp 1234cafe", mem1[8'h40]); end
  endtask
  initial begin
    test_reset;
    test_reset_mid_sb;
    test_sw_lw;
    test_sub_store;
    test_loads;
    test_errors;
    test_no_trap;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
